// File: rtl/pixel_packer.sv
// pixel_packer: unpacks DATA_WIDTH words into elements and repacks them into
// i_nch-element pixels. Optional overflow flag: PIXEL_PACKER_OVF_CHK_EN.
module pixel_packer #(
  parameter int BIT_WIDTH   = 8,
  parameter int NUM_CHANNEL = 3,
  parameter int DATA_WIDTH  = 32,
  parameter int BUF_DEPTH   = 16,
  parameter int IN_FLIGHT   = 2
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               i_clr,
  input  logic [$clog2(NUM_CHANNEL+1)-1:0]   i_nch,
  input  logic [DATA_WIDTH-1:0]              idat,
  input  logic                               ival,
  output logic                               ostall,
  output logic [BIT_WIDTH*NUM_CHANNEL-1:0]   odat,
  output logic                               oval,
  input  logic                               ordy,
  output logic [$clog2(BUF_DEPTH+1)-1:0]     o_fill,
  output logic                               o_err
);

  localparam int E  = DATA_WIDTH / BIT_WIDTH;
  localparam int PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int NW = $clog2(NUM_CHANNEL + 1);
  localparam int OW = BIT_WIDTH * NUM_CHANNEL;
  localparam int MW = BIT_WIDTH * BUF_DEPTH;

  localparam int unsigned E_U     = unsigned'(E);
  localparam int unsigned DEPTH_U = unsigned'(BUF_DEPTH);
  localparam int unsigned NCH_U   = unsigned'(NUM_CHANNEL);
  localparam int unsigned STALL_U = unsigned'((IN_FLIGHT + 1) * E);

  logic [MW-1:0] mem_q;
  logic [MW-1:0] mem_nxt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nxt;
  logic [NW-1:0] nch;
  logic [OW-1:0] pix;
  int unsigned   cnt_u;
  int unsigned   nch_u;
  logic          fits;
  logic          push;
  logic          pop;

  // Pointer advance modulo BUF_DEPTH; step is always below BUF_DEPTH,
  // so one conditional subtraction covers non-power-of-two depths.
  function automatic logic [PW-1:0] wrap(
    input logic [PW-1:0] base,
    input int unsigned   k
  );
    int unsigned s;
    s = 32'(base) + k;
    if (s >= DEPTH_U) s = s - DEPTH_U;
    return s[PW-1:0];
  endfunction

  // Out-of-range channel counts fall back to the full pixel width
  always_comb begin
    nch = i_nch;
    if (i_nch == '0 || 32'(i_nch) > NCH_U) nch = NW'(NUM_CHANNEL);
  end

  assign cnt_u = 32'(count);
  assign nch_u = 32'(nch);

  // Overflow test ignores a same-cycle pop: the word must fit as-is
  assign fits = (cnt_u + E_U <= DEPTH_U);
  assign push = ival && fits;
  assign pop  = (cnt_u >= nch_u) && (!oval || ordy);

  assign ostall = (cnt_u + STALL_U > DEPTH_U);
  assign o_fill = count;

  // Next element count from push and pop of this cycle
  always_comb begin
    int unsigned t;
    t = cnt_u;
    if (push) t = t + E_U;
    if (pop)  t = t - nch_u;
    count_nxt = CW'(t);
  end

  // Gather the next pixel from the read side; unused lanes are zero
  always_comb begin
    pix = '0;
    for (int c = 0; c < NUM_CHANNEL; c++) begin
      if (unsigned'(c) < nch_u) begin
        pix[c*BIT_WIDTH +: BIT_WIDTH] =
          mem_q[32'(wrap(rd_ptr, unsigned'(c)))*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  // Scatter the word's elements into the ring, element 0 first
  always_comb begin
    mem_nxt = mem_q;
    if (push && !rst && !i_clr) begin
      for (int k = 0; k < E; k++) begin
        mem_nxt[32'(wrap(wr_ptr, unsigned'(k)))*BIT_WIDTH +: BIT_WIDTH] =
          idat[k*BIT_WIDTH +: BIT_WIDTH];
      end
    end
  end

  // Element storage; contents are don't-care until pointers cover them
  always_ff @(posedge clk) begin
    mem_q <= mem_nxt;
  end

  // Pointers, count and output register; clear behaves as reset
  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      odat   <= '0;
      oval   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wrap(wr_ptr, E_U);
      if (pop) begin
        rd_ptr <= wrap(rd_ptr, nch_u);
        odat   <= pix;
        oval   <= 1'b1;
      end else if (oval && ordy) begin
        oval <= 1'b0;
      end
      count <= count_nxt;
    end
  end

`ifdef PIXEL_PACKER_OVF_CHK_EN
  logic err_q;

  // Sticky drop flag; survives clear, only reset releases it
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (!i_clr && ival && !fits) begin
      err_q <= 1'b1;
    end
  end

  assign o_err = err_q;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_pixel_packer.sv
// tb_pixel_packer: queue-based reference model, per-cycle compare,
// directed literal scenarios and a randomized soak.
module tb_pixel_packer;

  localparam int E     = 4;
  localparam int DEPTH = 16;
  localparam int STALL = 12;
`ifdef PIXEL_PACKER_OVF_CHK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        i_clr;
  logic [1:0]  i_nch;
  logic [31:0] idat;
  logic        ival;
  logic        ostall;
  logic [23:0] odat;
  logic        oval;
  logic        ordy;
  logic [4:0]  o_fill;
  logic        o_err;

  pixel_packer dut (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (i_clr),
    .i_nch  (i_nch),
    .idat   (idat),
    .ival   (ival),
    .ostall (ostall),
    .odat   (odat),
    .oval   (oval),
    .ordy   (ordy),
    .o_fill (o_fill),
    .o_err  (o_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int first_ov = -1;
  bit chk_en = 1'b0;

  byte unsigned mq[$];
  logic [23:0]  m_odat;
  logic         m_oval;
  logic         m_err;

  logic [23:0] acc[$];
  int          acc_cyc[$];
  logic [23:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ex(input logic [23:0] v);
    exp_q.push_back(v);
  endtask

  task automatic clear_log();
    acc.delete();
    acc_cyc.delete();
    exp_q.delete();
    first_ov = -1;
  endtask

  task automatic check_acc(input string name);
    check({name, "_n"}, 32'(acc.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < acc.size()) check(name, 32'(acc[i]), 32'(exp_q[i]));
      else check(name, 32'hxxxxxxxx, 32'(exp_q[i]));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ival = 1'b0;
    i_clr = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  always @(posedge clk) cyc++;

  // Reference: element queue; pop from the front, push whole words at back
  always @(posedge clk) begin
    int n;
    bit fit;
    bit dopop;
    if (rst) begin
      mq.delete();
      m_oval = 1'b0;
      m_odat = '0;
      m_err  = 1'b0;
    end else if (i_clr) begin
      mq.delete();
      m_oval = 1'b0;
      m_odat = '0;
    end else begin
      n = 32'(i_nch);
      fit = (mq.size() + E <= DEPTH);
      dopop = (mq.size() >= n) && (!m_oval || ordy);
      if (dopop) begin
        m_odat = '0;
        for (int i = 0; i < n; i++) m_odat[8*i +: 8] = mq.pop_front();
        m_oval = 1'b1;
      end else if (m_oval && ordy) begin
        m_oval = 1'b0;
      end
      if (ival) begin
        if (fit) begin
          for (int k = 0; k < E; k++) mq.push_back(idat[8*k +: 8]);
        end else begin
          m_err = EXP_ERR;
        end
      end
    end
  end

  // Compare DUT against the model mid-cycle, and log accepted pixels
  always @(negedge clk) begin
    if (chk_en) begin
      check("oval", 32'(oval), 32'(m_oval));
      check("odat", 32'(odat), 32'(m_odat));
      check("fill", 32'(o_fill), 32'(mq.size()));
      check("ostall", 32'(ostall), 32'(mq.size() + STALL > DEPTH));
      check("err", 32'(o_err), 32'(m_err));
      if (oval && ordy) begin
        acc.push_back(odat);
        acc_cyc.push_back(cyc);
      end
      if (oval && first_ov < 0) first_ov = cyc;
    end
  end

  initial begin
    int t0;
    rst = 1'b1;
    i_clr = 1'b0;
    ival = 1'b0;
    idat = '0;
    ordy = 1'b1;
    i_nch = 2'd3;
    tick();
    tick();
    chk_en = 1'b1;
    rst = 1'b0;
    check("rst_oval", 32'(oval), 32'd0);
    check("rst_odat", 32'(odat), 32'd0);
    check("rst_fill", 32'(o_fill), 32'd0);
    check("rst_stall", 32'(ostall), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);

    // basic packing
    clear_log();
    ival = 1'b1;
    idat = 32'h03020100;
    t0 = cyc;
    tick();
    idat = 32'h07060504;
    tick();
    idat = 32'h0B0A0908;
    tick();
    ival = 1'b0;
    repeat (6) tick();
    ex(24'h020100); ex(24'h050403); ex(24'h080706); ex(24'h0B0A09);
    check_acc("basic_pix");
    check("basic_lat", 32'(first_ov - t0), 32'd2);
    check("basic_fill", 32'(o_fill), 32'd0);

    // single channel
    do_reset();
    i_nch = 2'd1;
    clear_log();
    ival = 1'b1;
    idat = 32'h03020100;
    tick();
    ival = 1'b0;
    repeat (6) tick();
    ex(24'h000000); ex(24'h000001); ex(24'h000002); ex(24'h000003);
    check_acc("ch1_pix");
    if (acc_cyc.size() >= 4) check("ch1_b2b", 32'(acc_cyc[3] - acc_cyc[0]), 32'd3);
    else check("ch1_b2b", 32'(acc_cyc.size()), 32'd4);

    // backpressure
    do_reset();
    i_nch = 2'd3;
    ordy = 1'b0;
    clear_log();
    ival = 1'b1;
    idat = 32'h03020100;
    tick();
    idat = 32'h07060504;
    tick();
    ival = 1'b0;
    tick();
    tick();
    check("bp_hold", 32'(odat), 32'h020100);
    check("bp_oval", 32'(oval), 32'd1);
    check("bp_fill", 32'(o_fill), 32'd5);
    check("bp_stall", 32'(ostall), 32'd1);
    ordy = 1'b1;
    repeat (4) tick();
    check("bp_part_n", 32'(acc.size()), 32'd2);
    check("bp_part_fill", 32'(o_fill), 32'd2);
    check("bp_part_oval", 32'(oval), 32'd0);
    ival = 1'b1;
    idat = 32'h0B0A0908;
    tick();
    ival = 1'b0;
    repeat (5) tick();
    ex(24'h020100); ex(24'h050403); ex(24'h080706); ex(24'h0B0A09);
    check_acc("bp_pix");

    // overflow: 4,5,9,13 then the fifth word cannot fit
    do_reset();
    i_nch = 2'd3;
    ordy = 1'b0;
    clear_log();
    ival = 1'b1;
    for (int w = 0; w < 5; w++) begin
      idat = {8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)};
      tick();
    end
    ival = 1'b0;
    tick();
    check("ovf_fill", 32'(o_fill), 32'd13);
    check("ovf_err", 32'(o_err), 32'(EXP_ERR));
    ordy = 1'b1;
    repeat (8) tick();
    ex(24'h020100); ex(24'h050403); ex(24'h080706); ex(24'h0B0A09);
    ex(24'h0E0D0C);
    check_acc("ovf_pix");
    check("ovf_left", 32'(o_fill), 32'd1);

    // clear with fill=7 and a held pixel; sticky error survives
    i_clr = 1'b1;
    tick();
    i_clr = 1'b0;
    i_nch = 2'd1;
    ordy = 1'b0;
    ival = 1'b1;
    idat = 32'h03020100;
    tick();
    idat = 32'h07060504;
    tick();
    ival = 1'b0;
    check("clr_pre_fill", 32'(o_fill), 32'd7);
    check("clr_pre_oval", 32'(oval), 32'd1);
    i_clr = 1'b1;
    ival = 1'b1;
    idat = 32'h0B0A0908;
    tick();
    i_clr = 1'b0;
    ival = 1'b0;
    check("clr_fill", 32'(o_fill), 32'd0);
    check("clr_oval", 32'(oval), 32'd0);
    check("clr_stall", 32'(ostall), 32'd0);
    check("clr_err", 32'(o_err), 32'(EXP_ERR));
    tick();
    check("clr_drop", 32'(o_fill), 32'd0);
    do_reset();
    check("rst_err2", 32'(o_err), 32'd0);

    // randomized soak
    i_nch = 2'($urandom_range(1, 3));
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 249) == 0) begin
        i_clr = 1'b1;
        i_nch = 2'($urandom_range(1, 3));
      end else begin
        i_clr = 1'b0;
      end
      ival = ostall ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 1) == 1);
      idat = $urandom;
      ordy = ($urandom_range(0, 3) != 0);
      tick();
    end
    i_clr = 1'b0;
    ival = 1'b0;
    ordy = 1'b1;
    repeat (10) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
